// File: rtl/char_line_buffer.sv
// rtl/char_line_buffer.sv - terminal line buffer feeding the 8-digit seven-segment driver
// Optional cursor blink enabled by defining CHAR_LINE_CURSOR_BLINK_EN.
module char_line_buffer #(
    parameter int         LINE_LEN     = 16,
    parameter logic [4:0] BLANK_CODE   = 5'd31,
    parameter logic [4:0] CURSOR_CODE  = 5'd30,
    parameter int         BLINK_CYCLES = 50000000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_cmd,
    input  logic [4:0]                      in_char,
    output logic [39:0]                     display_word,
    output logic [$clog2(LINE_LEN+1)-1:0]   char_count,
    output logic                            full,
    output logic                            empty,
    output logic                            overflow,
    output logic                            busy
);

    localparam int CW = $clog2(LINE_LEN + 1);
    localparam int IW = $clog2(LINE_LEN);

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_BKSP  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;

    generate
        if (LINE_LEN < 8 || LINE_LEN > 31 || BLINK_CYCLES < 1 || CURSOR_CODE == BLANK_CODE) begin : g_bad_param
            $error("char_line_buffer: illegal parameter set");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic [4:0]    entry [LINE_LEN];
    logic [IW-1:0] clr_idx;
    logic [CW-1:0] cnt_m1;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] bs_idx;
    logic [39:0]   window;
    logic          xfer;

    assign xfer   = in_valid && in_ready;
    assign full   = (char_count == CW'(LINE_LEN));
    assign empty  = (char_count == '0);
    assign cnt_m1 = char_count - CW'(1);
    assign wr_idx = char_count[IW-1:0];
    assign bs_idx = cnt_m1[IW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            char_count <= '0;
            clr_idx    <= '0;
            for (int i = 0; i < LINE_LEN; i++) begin
                entry[i] <= BLANK_CODE;
            end
        end else begin
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        case (in_cmd)
                            CMD_WRITE: begin
                                if (!full) begin
                                    entry[wr_idx] <= in_char;
                                    char_count    <= char_count + CW'(1);
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                            CMD_BKSP: begin
                                if (!empty) begin
                                    entry[bs_idx] <= BLANK_CODE;
                                    char_count    <= cnt_m1;
                                end
                            end
                            CMD_CLEAR: begin
                                state    <= CLEAR;
                                clr_idx  <= '0;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    // Sweep every slot, not just the occupied ones, so the stall length is fixed.
                    entry[clr_idx] <= BLANK_CODE;
                    if (clr_idx == IW'(LINE_LEN - 1)) begin
                        char_count <= '0;
                        state      <= IDLE;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHAR_LINE_CURSOR_BLINK_EN
    localparam int SHIFT = 1;
    localparam int BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end
`else
    localparam int SHIFT = 0;
`endif

    // Newest character lands in the lowest digit not occupied by the cursor.
    always_comb begin
        int idx;
        idx    = 0;
        window = {8{BLANK_CODE}};
        for (int k = SHIFT; k < 8; k++) begin
            idx = int'(char_count) - 1 - (k - SHIFT);
            if (idx >= 0) begin
                window[5*k +: 5] = entry[idx[IW-1:0]];
            end
        end
`ifdef CHAR_LINE_CURSOR_BLINK_EN
        window[4:0] = blink_on ? CURSOR_CODE : BLANK_CODE;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_word <= {8{BLANK_CODE}};
        end else begin
            display_word <= window;
        end
    end

endmodule

// File: tb/tb_char_line_buffer.sv
// tb/tb_char_line_buffer.sv - directed self-checking bench for char_line_buffer
module tb_char_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cmd;
    logic [4:0]  in_char;
    logic [39:0] display_word;
    logic [4:0]  char_count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    bit ov_seen = 1'b0;

    localparam logic [39:0] ALL_BLANK = 40'hFF_FFFF_FFFF;

    char_line_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_char      (in_char),
        .display_word (display_word),
        .char_count   (char_count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow) ov_seen = 1'b1;
    end

    task automatic do_xfer(input logic [1:0] cmd, input logic [4:0] ch);
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_char  = ch;
        @(posedge clk);
    endtask

    task automatic settle;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset();
        n_cmp++; if (display_word !== ALL_BLANK) begin n_err++; $display("FAIL reset_display got=%h exp=%h", display_word, ALL_BLANK); end
        n_cmp++; if (char_count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", char_count); end
        n_cmp++; if ({empty, full, in_ready, busy, overflow} !== 5'b10100) begin n_err++; $display("FAIL reset_flags got=%b exp=10100", {empty, full, in_ready, busy, overflow}); end
    endtask

    task automatic test_write_three;
        logic [39:0] exp;
        exp = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd1, 5'd2, 5'd3};
        do_xfer(2'b00, 5'd1);
        do_xfer(2'b00, 5'd2);
        do_xfer(2'b00, 5'd3);
        settle();
        n_cmp++; if (display_word !== exp) begin n_err++; $display("FAIL write3_display got=%h exp=%h", display_word, exp); end
        n_cmp++; if (char_count !== 5'd3) begin n_err++; $display("FAIL write3_count got=%0d exp=3", char_count); end
    endtask

    task automatic test_backspace;
        logic [39:0] exp;
        apply_reset();
        ov_seen = 1'b0;
        for (int i = 0; i < 10; i++) do_xfer(2'b00, 5'(i));
        settle();
        exp = {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
        n_cmp++; if (display_word !== exp) begin n_err++; $display("FAIL ten_display got=%h exp=%h", display_word, exp); end
        do_xfer(2'b01, 5'd0);
        do_xfer(2'b01, 5'd0);
        settle();
        exp = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
        n_cmp++; if (display_word !== exp) begin n_err++; $display("FAIL bksp2_display got=%h exp=%h", display_word, exp); end
        n_cmp++; if (char_count !== 5'd8) begin n_err++; $display("FAIL bksp2_count got=%0d exp=8", char_count); end
    endtask

    task automatic test_reserved_and_blank_char;
        do_xfer(2'b11, 5'd9);
        settle();
        n_cmp++; if (char_count !== 5'd8) begin n_err++; $display("FAIL reserved_count got=%0d exp=8", char_count); end
        do_xfer(2'b00, 5'd31);
        settle();
        n_cmp++; if (char_count !== 5'd9) begin n_err++; $display("FAIL blankchar_count got=%0d exp=9", char_count); end
        n_cmp++; if (display_word[4:0] !== 5'd31 || display_word[9:5] !== 5'd7) begin n_err++; $display("FAIL blankchar_display got=%h exp_low=31,7", display_word); end
        do_xfer(2'b01, 5'd0);
        settle();
    endtask

    task automatic test_backspace_to_empty;
        for (int i = 0; i < 8; i++) do_xfer(2'b01, 5'd0);
        settle();
        n_cmp++; if (display_word !== ALL_BLANK) begin n_err++; $display("FAIL bksp_empty_display got=%h exp=%h", display_word, ALL_BLANK); end
        n_cmp++; if (char_count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL bksp_empty_count got=%0d/%b exp=0/1", char_count, empty); end
        do_xfer(2'b01, 5'd0);
        settle();
        n_cmp++; if (char_count !== 5'd0) begin n_err++; $display("FAIL bksp_at_empty_count got=%0d exp=0", char_count); end
        n_cmp++; if (display_word !== ALL_BLANK) begin n_err++; $display("FAIL bksp_at_empty_display got=%h exp=%h", display_word, ALL_BLANK); end
        n_cmp++; if (ov_seen !== 1'b0) begin n_err++; $display("FAIL bksp_overflow got=%b exp=0", ov_seen); end
    endtask

    task automatic test_overflow;
        logic [39:0] exp;
        exp = {5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
        for (int i = 0; i < 16; i++) do_xfer(2'b00, 5'(i));
        settle();
        n_cmp++; if (char_count !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL fill_count got=%0d/%b exp=16/1", char_count, full); end
        n_cmp++; if (display_word !== exp) begin n_err++; $display("FAIL fill_display got=%h exp=%h", display_word, exp); end
        do_xfer(2'b00, 5'd5);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_pulse got=%b exp=1", overflow); end
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL overflow_width got=%b exp=0", overflow); end
        n_cmp++; if (char_count !== 5'd16) begin n_err++; $display("FAIL overflow_count got=%0d exp=16", char_count); end
        n_cmp++; if (display_word !== exp) begin n_err++; $display("FAIL overflow_display got=%h exp=%h", display_word, exp); end
    endtask

    task automatic test_clear;
        int low;
        low = 0;
        do_xfer(2'b10, 5'd0);
        @(negedge clk);
        in_cmd  = 2'b00;
        in_char = 5'd7;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) break;
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy got=%b exp=1", busy); end
            low++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++; if (low !== 16) begin n_err++; $display("FAIL clear_ready_low got=%0d exp=16", low); end
        n_cmp++; if (char_count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL clear_count got=%0d/%b exp=0/1", char_count, empty); end
        @(negedge clk);
        n_cmp++; if (display_word !== ALL_BLANK) begin n_err++; $display("FAIL clear_display got=%h exp=%h", display_word, ALL_BLANK); end
        n_cmp++; if (char_count !== 5'd0) begin n_err++; $display("FAIL clear_held_offer got=%0d exp=0", char_count); end
    endtask

    task automatic test_reset_mid_clear;
        logic [39:0] exp;
        exp = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd4};
        for (int i = 0; i < 16; i++) do_xfer(2'b00, 5'(i + 3));
        do_xfer(2'b10, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midclear_busy got=%b exp=1", busy); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if ({in_ready, busy, overflow, empty} !== 4'b1001) begin n_err++; $display("FAIL midclear_reset_flags got=%b exp=1001", {in_ready, busy, overflow, empty}); end
        n_cmp++; if (char_count !== 5'd0) begin n_err++; $display("FAIL midclear_reset_count got=%0d exp=0", char_count); end
        n_cmp++; if (display_word !== ALL_BLANK) begin n_err++; $display("FAIL midclear_reset_display got=%h exp=%h", display_word, ALL_BLANK); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midclear_release_ready got=%b exp=1", in_ready); end
        do_xfer(2'b00, 5'd4);
        settle();
        n_cmp++; if (display_word !== exp) begin n_err++; $display("FAIL midclear_after_write got=%h exp=%h", display_word, exp); end
        n_cmp++; if (char_count !== 5'd1) begin n_err++; $display("FAIL midclear_after_count got=%0d exp=1", char_count); end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_cmd   = 2'b00;
        in_char  = 5'd0;
        test_reset();
        test_write_three();
        test_backspace();
        test_reserved_and_blank_char();
        test_backspace_to_empty();
        test_overflow();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/char_line_buffer.md
Name: char_line_buffer

Overview:
- Terminal line buffer that sits directly upstream of the 8-digit seven-segment driver.
- Accepts character codes and edit commands over a valid/ready handshake and stores up to LINE_LEN characters.
- Presents the most recent 8 characters as a packed 40-bit word for the driver's signal_in.
- Runs on the same clk as the display driver.

Parameters:
- LINE_LEN, 16, line capacity in characters; legal range 8..31.
- BLANK_CODE, 5'd31, code written to empty or erased positions.
- CURSOR_CODE, 5'd30, code shown for the cursor (optional feature only).
- BLINK_CYCLES, 50000000, clk cycles per cursor blink half-period (optional feature only).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  command/character offered.
- in_ready  out  1  block can accept a transfer this cycle.
- in_cmd  in  2  2'b00 write char, 2'b01 backspace, 2'b10 clear, 2'b11 reserved (no-op).
- in_char  in  5  character code; used only with in_cmd=00.
- display_word  out  40  digit_k = bits [5k+4:5k]; digit_0 is the newest character.
- char_count  out  $clog2(LINE_LEN+1)  characters currently held (5 bits at default).
- full  out  1  char_count == LINE_LEN.
- empty  out  1  char_count == 0.
- overflow  out  1  one-cycle pulse when a write is dropped because the buffer is full.
- busy  out  1  clear sequence in progress.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - All buffer entries = BLANK_CODE; display_word = {8{BLANK_CODE}} (40'hFF_FFFF_FFFF at default).
  - char_count = 0; empty = 1; full = 0; overflow = 0; busy = 0.
  - in_ready = 1 once reset deasserts; state = IDLE.
- Handshake: a transfer occurs on a rising clk edge where in_valid && in_ready. in_cmd and in_char are sampled at that edge. At most one command per cycle.
- FSM states are IDLE and CLEAR.
- IDLE: in_ready = 1.
  - Write, char_count < LINE_LEN: entry[char_count] <= in_char; char_count++. Any 5-bit code is stored as given, including BLANK_CODE.
  - Write, full: char dropped; buffer and count unchanged; overflow = 1 for exactly the next cycle.
  - Backspace, char_count > 0: entry[char_count-1] <= BLANK_CODE; char_count--.
  - Backspace, empty: no-op, no flag.
  - Clear: go to CLEAR; clear index = 0.
  - Reserved code: accepted, no effect.
- CLEAR: in_ready = 0 and busy = 1.
  - Blanks one entry per cycle, index 0 to LINE_LEN-1, so in_ready is low for exactly LINE_LEN cycles.
  - On the final entry: char_count <= 0 and return to IDLE. in_ready = 1 the following cycle.
  - Offers presented during CLEAR are not accepted and are held by the source.
- Display window:
  - Registered. digit_k = entry[char_count-1-k] when char_count-1-k >= 0, else BLANK_CODE.
  - A transfer at edge N updates buffer and count at edge N; display_word reflects it at edge N+1.
- full and empty are combinational from char_count.
- Reset asserted mid-CLEAR or mid-anything: immediate return to reset values; the clear sequence is abandoned.

Optional Feature:
- Macro: CHAR_LINE_CURSOR_BLINK_EN.
- When defined:
  - A counter toggles a blink phase every BLINK_CYCLES clk cycles; the phase resets to "on".
  - digit_0 shows CURSOR_CODE in the "on" phase and BLANK_CODE in the "off" phase.
  - The window shifts by one: digit_k = entry[char_count-k] for k = 1..7.
  - When full, the cursor is still shown.
- When undefined: no counter logic; the window is as specified in Behaviour.

Test Plan:
- Reset, then release -> display_word = 40'hFF_FFFF_FFFF, char_count = 0, empty = 1, in_ready = 1.
- Write chars 1, 2, 3 back-to-back -> one cycle after the last transfer: digit_0 = 3, digit_1 = 2, digit_2 = 1, digits 3-7 = 31, char_count = 3.
- Write 0..9, then backspace x2 -> before backspace: digit_0 = 9 … digit_7 = 2. After backspace: digit_0 = 7 … digit_7 = 0, char_count = 8.
- Backspace x8 more, then one more backspace at empty -> display all 31; char_count stays 0; overflow never asserted.
- Write 16 chars, then a 17th (code 5) -> overflow high exactly one cycle; char_count = 16; display_word unchanged.
- Clear from full -> in_ready low exactly 16 cycles; then char_count = 0, display all 31. Repeat with reset asserted at clear cycle 5 -> immediate reset values, in_ready = 1 after release.
- With CHAR_LINE_CURSOR_BLINK_EN and BLINK_CYCLES = 4 -> digit_0 alternates 30 / 31 every 4 cycles.
